axis_rr_packet_arbiter: RTL
===========================

Name: axis_rr_packet_arbiter

Overview:
- Shares one AXI4-Stream master output between NUM_SRC AXI4-Stream sources, such as several 8-word counter-pattern stream generators.
- Arbitrates round-robin at packet granularity. The grant is held from the first beat until the TLAST beat of the granted source is accepted.
- One registered output stage sits between the selected source and the master port. Simple status outputs feed the control/debug logic.

Parameters:
- C_M_AXIS_TDATA_WIDTH, 32, data width of every source and of the master port.
- NUM_SRC, 4, number of sources, 2..8.
- CNT_WIDTH, 16, width of the per-port accepted-packet counter.

Ports:
- M_AXIS_ACLK  in  1  clock, all logic rising-edge.
- M_AXIS_ARESET  in  1  asynchronous active-high reset.
- S_AXIS_TVALID  in  NUM_SRC  per-source valid, bit i = source i.
- S_AXIS_TDATA  in  NUM_SRC*C_M_AXIS_TDATA_WIDTH  flattened data, source i in slice i.
- S_AXIS_TLAST  in  NUM_SRC  per-source last.
- S_AXIS_TREADY  out  NUM_SRC  per-source ready.
- M_AXIS_TVALID  out  1  output valid.
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  output data.
- M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  constant all ones.
- M_AXIS_TLAST  out  1  output last.
- M_AXIS_TREADY  in  1  downstream ready.
- GRANT_ID  out  $clog2(NUM_SRC)  index of the current or last granted source.
- BUSY  out  1  high while in state LOCKED.
- PKT_COUNT  out  CNT_WIDTH  packets forwarded (TLAST accepted at master port), wraps.

Behaviour:
- Reset (async, M_AXIS_ARESET=1):
  - state=IDLE.
  - M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0.
  - S_AXIS_TREADY=0, GRANT_ID=NUM_SRC-1, BUSY=0, PKT_COUNT=0.
  - Outputs fall immediately on assertion, not at the next edge. This also applies mid-packet; no partial-packet recovery.
- State IDLE:
  - All S_AXIS_TREADY=0.
  - If any S_AXIS_TVALID bit is set, select the first set bit scanning GRANT_ID+1, GRANT_ID+2, ... modulo NUM_SRC.
  - Register the selected index into GRANT_ID and go to LOCKED at the next edge.
  - Arbitration costs exactly one cycle per packet. The source's first beat can be accepted no earlier than the cycle after the request is seen.
- State LOCKED:
  - S_AXIS_TREADY[GRANT_ID] = !M_AXIS_TVALID || M_AXIS_TREADY. All other ready bits are 0.
  - An input handshake on the granted source loads TDATA/TLAST into the output register and sets M_AXIS_TVALID at the next edge, so input-to-output latency is 1 cycle.
  - An output handshake with no new input beat clears M_AXIS_TVALID.
  - Simultaneous output and input handshake: the register reloads and valid stays 1. Full throughput is 1 beat/cycle.
  - The input handshake of a beat with TLAST=1 returns the state to IDLE at the next edge. That packet's tail still drains from the output register.
- Grant behaviour:
  - The granted source dropping TVALID mid-packet does not release the grant; the block waits indefinitely.
  - Non-granted sources are never consumed. Their TVALID/TDATA must be held by the AXI rule; the block imposes nothing further.
- Output register:
  - M_AXIS_TDATA/TLAST hold stable while M_AXIS_TVALID=1 and M_AXIS_TREADY=0 (AXI rule).
  - TDATA is not cleared on drain; only valid drops.
- PKT_COUNT increments by 1 on each M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST and wraps to 0 past all-ones.
- Fairness:
  - With all sources continuously requesting, grants rotate 0,1,...,NUM_SRC-1,0.
  - A single requester is re-granted back-to-back with one idle input cycle between packets.
- Out-of-range GRANT_ID values are not reachable. The state register is 1 bit.

Test Plan:
- Reset then single packet:
  - Stimulus: NUM_SRC=4; source 2 sends 8 beats of data 1..8, last on beat 8; M_AXIS_TREADY=1.
  - Required: GRANT_ID=2 one cycle after TVALID rises; first M_AXIS_TVALID two cycles after request; 8 consecutive beats 1..8 with TLAST only on 8; PKT_COUNT=1; BUSY low afterwards.
- All four requesting, each with 3-beat packets:
  - Required: output packet order is sources 0,1,2,3,0. No beat interleaving between packets. One idle output cycle between packets.
- Backpressure:
  - Stimulus: M_AXIS_TREADY toggles 1,0,0,1,... during an 8-beat packet.
  - Required: no beat lost or duplicated; TDATA/TLAST stable while stalled; S_AXIS_TREADY of the granted source is 0 whenever M_AXIS_TVALID=1 and M_AXIS_TREADY=0.
- Mid-packet source gap:
  - Stimulus: source 1 is granted and drops TVALID for 5 cycles after beat 3 while source 0 requests.
  - Required: grant stays at 1; source 0 READY stays 0 until source 1's TLAST is accepted; source 0 is then granted.
- Async reset mid-packet:
  - Stimulus: assert M_AXIS_ARESET between clock edges during beat 4.
  - Required: M_AXIS_TVALID and all S_AXIS_TREADY go 0 without a clock edge; PKT_COUNT=0; after release, the next arbitration starts from source 0.
- PKT_COUNT wrap:
  - Stimulus: CNT_WIDTH=4; send 17 single-beat packets.
  - Required: PKT_COUNT=1.

Source files
------------

// File: rtl/axis_rr_packet_arbiter.sv
// Round-robin, packet-granular AXI4-Stream arbiter: NUM_SRC slave streams share one
// master port through a single registered output stage, with grant/busy/packet status.
module axis_rr_packet_arbiter #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int NUM_SRC              = 4,
    parameter int CNT_WIDTH            = 16
) (
    input  logic                                      M_AXIS_ACLK,
    input  logic                                      M_AXIS_ARESET,
    input  logic [NUM_SRC-1:0]                        S_AXIS_TVALID,
    input  logic [NUM_SRC*C_M_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [NUM_SRC-1:0]                        S_AXIS_TLAST,
    output logic [NUM_SRC-1:0]                        S_AXIS_TREADY,
    output logic                                      M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]           M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]         M_AXIS_TSTRB,
    output logic                                      M_AXIS_TLAST,
    input  logic                                      M_AXIS_TREADY,
    output logic [$clog2(NUM_SRC)-1:0]                GRANT_ID,
    output logic                                      BUSY,
    output logic [CNT_WIDTH-1:0]                      PKT_COUNT
);

    localparam int W  = C_M_AXIS_TDATA_WIDTH;
    localparam int GW = $clog2(NUM_SRC);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                stateQ;
    logic [GW-1:0]         grantQ;
    logic [GW-1:0]         grantD;
    logic [GW-1:0]         cand;
    logic [W-1:0]          dataQ;
    logic                  lastQ;
    logic                  validQ;
    logic [CNT_WIDTH-1:0]  pktCntQ;
    logic [W-1:0]          srcData [NUM_SRC];
    logic                  selValid;
    logic                  selLast;
    logic                  outReady;
    logic                  inHs;
    logic                  outHs;
    logic [NUM_SRC-1:0]    readyVec;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign srcData[g] = S_AXIS_TDATA[g*W +: W];
    end

    assign selValid = S_AXIS_TVALID[grantQ];
    assign selLast  = S_AXIS_TLAST[grantQ];
    assign outReady = !validQ || M_AXIS_TREADY;
    assign inHs     = (stateQ == LOCKED) && selValid && outReady;
    assign outHs    = validQ && M_AXIS_TREADY;

    // Scan from the farthest offset down so the nearest requester after the last grant wins.
    always_comb begin
        grantD = grantQ;
        cand   = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = GW'((int'(grantQ) + k) % NUM_SRC);
            if (S_AXIS_TVALID[cand]) begin
                grantD = cand;
            end
        end
    end

    always_comb begin
        readyVec = '0;
        if (stateQ == LOCKED) begin
            readyVec[grantQ] = outReady;
        end
    end

    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) begin
            stateQ  <= IDLE;
            grantQ  <= GW'(NUM_SRC - 1);
            dataQ   <= '0;
            lastQ   <= 1'b0;
            validQ  <= 1'b0;
            pktCntQ <= '0;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (|S_AXIS_TVALID) begin
                        grantQ <= grantD;
                        stateQ <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (inHs && selLast) begin
                        stateQ <= IDLE;
                    end
                end
            endcase

            // The tail beat keeps draining from the output register after the grant drops.
            if (inHs) begin
                dataQ  <= srcData[grantQ];
                lastQ  <= selLast;
                validQ <= 1'b1;
            end else if (outHs) begin
                validQ <= 1'b0;
            end

            if (outHs && lastQ) begin
                pktCntQ <= pktCntQ + CNT_WIDTH'(1);
            end
        end
    end

    assign S_AXIS_TREADY = readyVec;
    assign M_AXIS_TVALID = validQ;
    assign M_AXIS_TDATA  = dataQ;
    assign M_AXIS_TLAST  = lastQ;
    assign M_AXIS_TSTRB  = '1;
    assign GRANT_ID      = grantQ;
    assign BUSY          = (stateQ == LOCKED);
    assign PKT_COUNT     = pktCntQ;

endmodule
